pipelined_approx_mult_pam: RTL

//   Parametrised, pipelined unsigned WxW approximate multiplier with a valid/ready stream interface.
//   Low partial-product rows (x bits below L) are combined in row pairs using truncation and OR-compression.

---
 rtl/pipelined_approx_mult_pam.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipelined_approx_mult_pam.sv
// Unsigned WxW multiplier: low x rows are approximated in pairs, high rows are exact, exact_mode bypasses the approximation.
// Latency 2, throughput 1; when z is not taken, both stages hold and in_ready drops in the same cycle.
module pipelined_approx_mult_pam #(
  parameter int W      = 8,
  parameter int L      = 6,
  parameter int T_COL  = 6,
  parameter int OR_COL = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    y,
  input  logic            exact_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  z
);

  localparam int ZW = 2 * W;
  localparam int NP = L / 2;

  function automatic logic [ZW-1:0] col_mask(input int lo, input int hi);
    logic [ZW-1:0] m;
    for (int c = 0; c < ZW; c++) m[c] = (c >= lo) && (c < hi);
    return m;
  endfunction

  function automatic logic [ZW-1:0] pp_row(input logic xb, input logic [W-1:0] yv, input int sh);
    return {{W{1'b0}}, yv & {W{xb}}} << sh;
  endfunction

  localparam logic [ZW-1:0] OR_MASK = col_mask(T_COL, OR_COL);
  localparam logic [ZW-1:0] HI_MASK = col_mask(OR_COL, ZW);

  logic            adv;
  logic            s1_vld_q, s1_vld_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic            mode_q, mode_d;
  logic [ZW-1:0]   hi_prod_q, hi_prod_d;
  logic [ZW-1:0]   pair_sum_q [NP];
  logic [ZW-1:0]   pair_sum_d [NP];
  logic [ZW-1:0]   pair_sum_c [NP];
  logic [ZW-1:0]   row_a [NP];
  logic [ZW-1:0]   row_b [NP];
  logic            out_valid_q, out_valid_d;
  logic [ZW-1:0]   z_q, z_d;
  logic [ZW-1:0]   approx_sum;
  logic [ZW-1:0]   exact_prod;

  // Columns below T_COL vanish, the middle band keeps one bit per column, the top band adds both rows.
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      row_a[k]      = pp_row(x[2*k], y, 2*k);
      row_b[k]      = pp_row(x[2*k+1], y, 2*k+1);
      pair_sum_c[k] = ((row_a[k] | row_b[k]) & OR_MASK)
                    + (row_a[k] & HI_MASK)
                    + (row_b[k] & HI_MASK);
    end
  end

  always_comb begin
    adv        = !out_valid_q || out_ready;
    s1_vld_d   = s1_vld_q;
    x_d        = x_q;
    y_d        = y_q;
    mode_d     = mode_q;
    hi_prod_d  = hi_prod_q;
    pair_sum_d = pair_sum_q;
    if (adv) begin
      s1_vld_d   = in_valid;
      x_d        = x;
      y_d        = y;
      mode_d     = exact_mode;
      hi_prod_d  = (ZW'(x[W-1:L]) * ZW'(y)) << L;
      pair_sum_d = pair_sum_c;
    end
  end

  always_comb begin
    approx_sum = hi_prod_q;
    for (int k = 0; k < NP; k++) approx_sum = approx_sum + pair_sum_q[k];
    exact_prod  = ZW'(x_q) * ZW'(y_q);
    out_valid_d = out_valid_q;
    z_d         = z_q;
    if (adv) begin
      out_valid_d = s1_vld_q;
      // z only moves when a real item arrives, so a bubble leaves the last product visible.
      if (s1_vld_q) z_d = mode_q ? exact_prod : approx_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q        <= x_d;
    y_q        <= y_d;
    mode_q     <= mode_d;
    hi_prod_q  <= hi_prod_d;
    pair_sum_q <= pair_sum_d;
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign z         = z_q;

endmodule
